// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_pkg
//  Description : Shared types and constants for the multiply/divide
//                sequencing controller: state encoding, default iteration
//                counts and the iteration-counter width derivation.
//  Revision    : 1.0  initial release
// ============================================================================
package multdiv_pkg;

    // Default datapath step counts (radix-4 Booth multiply, restoring divide)
    localparam int c_MULT_ITERS_DEF = 16;
    localparam int c_DIV_ITERS_DEF  = 32;

    // Controller states, encoding fixed so the datapath can decode them directly
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter width large enough to represent the larger of the two counts
    function automatic int cnt_width(input int mult_iters, input int div_iters);
        int max_iters;
        max_iters = (mult_iters > div_iters) ? mult_iters : div_iters;
        return $clog2(max_iters + 1);
    endfunction

    localparam int c_CNT_W_DEF = cnt_width(c_MULT_ITERS_DEF, c_DIV_ITERS_DEF);

endpackage : multdiv_pkg
`default_nettype wire

// File: rtl/multdiv_iter_counter.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_iter_counter
//  Description : Iteration counter for the multiply/divide sequencer. Clears
//                synchronously, increments when enabled and flags the last
//                iteration (count == terminal count - 1).
//  Revision    : 1.0  initial release
// ============================================================================
module multdiv_iter_counter
    import multdiv_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_n,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_last
);

    logic [CNT_W-1:0] r_count;

    // Count register: clear has priority over increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_at_last = (r_count == (i_n - CNT_W'(1)));

endmodule : multdiv_iter_counter
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_ctrl
//  Description : Sequencing controller for the shared multi-cycle multiply /
//                divide datapath. IDLE -> LOAD -> RUN (N steps) -> DONE, with
//                divide-by-zero short-circuiting LOAD -> DONE. Produces a
//                one-cycle result-ready/exception pulse and a busy stall.
//                Optional macro MULTDIV_ABORT_EN adds the ctrl_abort input
//                which cancels an operation in LOAD or RUN.
//  Revision    : 1.0  initial release
// ============================================================================
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int MULT_ITERS = c_MULT_ITERS_DEF,
    parameter int DIV_ITERS  = c_DIV_ITERS_DEF,
    parameter int CNT_W      = c_CNT_W_DEF
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
`ifdef MULTDIV_ABORT_EN
    input  logic             ctrl_abort,
`endif
    input  logic             divisor_zero,
    input  logic             dp_overflow,
    output logic             op_load,
    output logic             op_is_div,
    output logic             step_en,
    output logic [CNT_W-1:0] iter_idx,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_MULT_N = CNT_W'(MULT_ITERS);
    localparam logic [CNT_W-1:0] c_DIV_N  = CNT_W'(DIV_ITERS);

    state_t           r_state;
    state_t           w_next;
    logic             r_op_is_div;
    logic             r_exc_pending;
    logic             w_abort;
    logic             w_start;
    logic [CNT_W-1:0] w_term;
    logic [CNT_W-1:0] w_count;
    logic             w_at_last;
    logic             w_cnt_clear;
    logic             w_cnt_en;

`ifdef MULTDIV_ABORT_EN
    assign w_abort = ctrl_abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_term  = r_op_is_div ? c_DIV_N : c_MULT_N;

    // Counter only advances in RUN and stops on the last step so it never wraps
    assign w_cnt_en    = (r_state == ST_RUN) && !w_abort && !w_at_last;
    assign w_cnt_clear = (r_state != ST_RUN) || w_abort;

    multdiv_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk       (clock),
        .rst_n     (ctrl_reset_n),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_en),
        .i_n       (w_term),
        .o_count   (w_count),
        .o_at_last (w_at_last)
    );

    // Next-state decode; abort only acts before a result exists
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_abort && w_start) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_abort) begin
                    w_next = ST_IDLE;
                end else if (r_op_is_div && divisor_zero) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_next = ST_IDLE;
                end else if (w_at_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = w_start ? ST_LOAD : ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the operation type on acceptance; multiply wins when both pulse
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            r_op_is_div <= 1'b0;
        end else if (w_next == ST_LOAD) begin
            r_op_is_div <= !ctrl_MULT;
        end
    end

    // Divide-by-zero is only known in LOAD; carry it into the DONE cycle
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            r_exc_pending <= 1'b0;
        end else if ((r_state == ST_LOAD) && (w_next == ST_DONE)) begin
            r_exc_pending <= 1'b1;
        end else if (w_next != ST_DONE) begin
            r_exc_pending <= 1'b0;
        end
    end

    assign op_load        = (r_state == ST_LOAD);
    assign step_en        = (r_state == ST_RUN);
    assign iter_idx       = (r_state == ST_RUN) ? w_count : '0;
    assign data_resultRDY = (r_state == ST_DONE);
    assign data_exception = (r_state == ST_DONE) &&
                            (r_exc_pending || (!r_op_is_div && dp_overflow));
    assign busy           = (r_state != ST_IDLE);
    assign op_is_div      = r_op_is_div;

endmodule : multdiv_ctrl
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_ctrl
//  Description : Scoreboard bench for multdiv_ctrl. Accepted operations are
//                queued with their start cycle; a monitor derives the expected
//                per-cycle strobes and result pulse from the operation timing
//                rules. Covers MULTDIV_ABORT_EN when that macro is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multdiv_ctrl;

    localparam int MI = 16;
    localparam int DI = 32;

    logic       clock = 1'b0;
    logic       ctrl_reset_n, ctrl_MULT, ctrl_DIV, divisor_zero, dp_overflow;
`ifdef MULTDIV_ABORT_EN
    logic       ctrl_abort;
`endif
    logic       op_load, op_is_div, step_en, data_resultRDY, data_exception, busy;
    logic [5:0] iter_idx;

    always #5 clock = ~clock;

    multdiv_ctrl dut (
        .clock          (clock),
        .ctrl_reset_n   (ctrl_reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
`ifdef MULTDIV_ABORT_EN
        .ctrl_abort     (ctrl_abort),
`endif
        .divisor_zero   (divisor_zero),
        .dp_overflow    (dp_overflow),
        .op_load        (op_load),
        .op_is_div      (op_is_div),
        .step_en        (step_en),
        .iter_idx       (iter_idx),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .busy           (busy)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        int start;
        bit is_div;
        bit dz;
    } op_t;

    op_t q[$];
    bit  mon_en   = 1'b0;
    int  accept   = 0;
    int  load_cyc = -1;
    bit  plan_dz  = 1'b0;

    // Length of an operation from its start cycle to its result cycle
    function automatic int op_len(input bit is_div, input bit dz);
        if (is_div && dz) return 2;
        return 2 + (is_div ? DI : MI);
    endfunction

    // Monitor: expected outputs follow from the oldest queued operation
    int rel;
    bit e_load, e_step, e_rdy, e_busy, e_div, e_exc;
    int e_idx;
    always @(negedge clock) begin
        if (mon_en) begin
            e_load = 0; e_step = 0; e_rdy = 0; e_busy = 0; e_div = 0; e_exc = 0; e_idx = 0;
            if (q.size() > 0) begin
                rel = cyc - q[0].start;
                if (rel >= 1) begin
                    e_busy = 1;
                    e_div  = q[0].is_div;
                    if (rel == 1) begin
                        e_load = 1;
                    end else if (rel < op_len(q[0].is_div, q[0].dz)) begin
                        e_step = 1;
                        e_idx  = rel - 2;
                    end else begin
                        e_rdy = 1;
                        e_exc = (q[0].is_div && q[0].dz) || (!q[0].is_div && dp_overflow);
                    end
                end
            end
            check("load/step/rdy/busy/idx",
                  32'({op_load, step_en, data_resultRDY, busy, iter_idx}),
                  32'({e_load, e_step, e_rdy, e_busy, 6'(e_idx)}));
            if (e_busy) check("op_is_div", 32'(op_is_div), 32'(e_div));
            if (e_rdy) begin
                check("exception", 32'(data_exception), 32'(e_exc));
                void'(q.pop_front());
            end
        end
    end

    // One stimulus cycle; kind 0=mult 1=div 2=div-by-zero 3=mult+div together
    task automatic drive_cycle(input bit want, input int kind);
        op_t op;
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        divisor_zero = (cyc == load_cyc) ? plan_dz : 1'($urandom);
        dp_overflow  = 1'($urandom);
        if (want) begin
            ctrl_MULT = (kind == 0) || (kind == 3);
            ctrl_DIV  = (kind != 0);
            if (cyc >= accept) begin
                op.start  = cyc;
                op.is_div = (kind == 1) || (kind == 2);
                op.dz     = (kind == 2);
                plan_dz   = op.is_div ? op.dz : 1'($urandom);
                load_cyc  = cyc + 1;
                accept    = cyc + op_len(op.is_div, op.dz);
                q.push_back(op);
            end
        end
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    int c0;

    initial begin
        ctrl_reset_n = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        divisor_zero = 1'b0; dp_overflow = 1'b0;
`ifdef MULTDIV_ABORT_EN
        ctrl_abort = 1'b0;
`endif
        @(posedge clock); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        ctrl_reset_n = 1'b1;
        accept = cyc;

        // Directed kinds first, each issued in the previous op's result cycle
        for (int k = 0; k < 4; k++) begin
            while (cyc < accept) drive_cycle(1'b0, 0);
            drive_cycle(1'b1, k);
        end

        // Random traffic, including start pulses while busy
        for (int i = 0; i < 1200; i++) begin
            drive_cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
        end
        while (cyc < accept + 2) drive_cycle(1'b0, 0);
        check("queue drained", 32'(q.size()), 32'd0);

        // Reset in the middle of RUN aborts the multiply without a result
        mon_en = 1'b0;
        c0 = cyc;
        ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        @(negedge clock);
        check("run idx 7", 32'({step_en, iter_idx}), 32'({1'b1, 6'd7}));
        ctrl_reset_n = 1'b0;
        @(posedge clock); #1;
        ctrl_reset_n = 1'b1;
        @(negedge clock);
        check("outputs after reset",
              32'({op_load, op_is_div, step_en, iter_idx, data_resultRDY, data_exception, busy}),
              32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("no rdy after reset", 32'({data_resultRDY, busy}), 32'd0);
        end
        @(posedge clock); #1;
        accept = cyc; load_cyc = -1; mon_en = 1'b1;
        drive_cycle(1'b1, 0);
        while (cyc < accept + 2) drive_cycle(1'b0, 0);

`ifdef MULTDIV_ABORT_EN
        // Abort at iter_idx 5, then a normal start three cycles later
        mon_en = 1'b0;
        ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        @(negedge clock);
        check("abort idx 5", 32'({step_en, iter_idx}), 32'({1'b1, 6'd5}));
        ctrl_abort = 1'b1;
        @(posedge clock); #1;
        ctrl_abort = 1'b0;
        @(negedge clock);
        check("after abort", 32'({busy, data_resultRDY, data_exception}), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        accept = cyc; load_cyc = -1; mon_en = 1'b1;
        drive_cycle(1'b1, 1);
        while (cyc < accept + 2) drive_cycle(1'b0, 0);
`endif

        check("queue empty at end", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_multdiv_ctrl
`default_nettype wire
